// File: rtl/bus_snoop_responder.sv
// bus_snoop_responder: takes one LLC bus op at a time, broadcasts it as a snoop, combines the peer results, then runs the owner flush and the memory access
module bus_snoop_responder #(
  parameter int ADDR_BITS     = 32,
  parameter int N_SNOOPERS    = 3,
  parameter int SNOOP_TIMEOUT = 8,
  parameter int MEM_LATENCY   = 4,
  parameter int CNT_BITS      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [ADDR_BITS-1:0]    req_addr,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_result,
  output logic                    snp_valid,
  output logic [2:0]              snp_op,
  output logic [ADDR_BITS-1:0]    snp_addr,
  input  logic [N_SNOOPERS-1:0]   snp_rsp_valid,
  input  logic [2*N_SNOOPERS-1:0] snp_rsp,
  input  logic                    wb_valid,
  output logic                    err_multi_hitm,
  output logic                    err_timeout,
  output logic                    err_bad_op,
  output logic [CNT_BITS-1:0]     op_count,
  output logic [CNT_BITS-1:0]     hitm_count
);
  localparam int TMAX = SNOOP_TIMEOUT > MEM_LATENCY ? SNOOP_TIMEOUT : MEM_LATENCY;
  localparam int CW = $clog2(TMAX + 1);
  localparam logic [2:0] OP_WRITE = 3'd2, OP_INV = 3'd3;
  typedef enum logic [2:0] {IDLE, BCAST, COLLECT, FLUSH, MEM, RESP} state_t;
  state_t state;
  logic [2:0] op;
  logic [N_SNOOPERS-1:0] mask, cap_mask;
  logic [2*N_SNOOPERS-1:0] res_q;
  logic [CW-1:0] tmr;
  logic [1:0] cur, comb_res;
  logic hitm_any, hitm_multi, hit_any, all_cap, tmr_end, legal;
  assign cap_mask = mask | snp_rsp_valid;
  assign all_cap  = &cap_mask;
  assign tmr_end  = tmr == CW'(SNOOP_TIMEOUT - 1);
  assign legal    = req_op != 3'd0 && req_op <= 3'd4;
  assign comb_res = hitm_any ? 2'd2 : hit_any ? 2'd1 : 2'd0;
  // Already-captured agents use their stored result; a fresh strobe this cycle counts immediately
  always_comb begin
    cur = 2'd0;
    hitm_any = 1'b0;
    hitm_multi = 1'b0;
    hit_any = 1'b0;
    for (int i = 0; i < N_SNOOPERS; i++) begin
      cur = mask[i] ? res_q[2*i+:2] : snp_rsp[2*i+:2];
      hitm_multi = hitm_multi | (hitm_any & cap_mask[i] & (cur == 2'd2));
      hitm_any = hitm_any | (cap_mask[i] & (cur == 2'd2));
      hit_any = hit_any | (cap_mask[i] & (cur == 2'd1));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_result <= 2'd0;
      snp_valid <= 1'b0;
      snp_op <= 3'd0;
      snp_addr <= '0;
      err_multi_hitm <= 1'b0;
      err_timeout <= 1'b0;
      err_bad_op <= 1'b0;
      op_count <= '0;
      hitm_count <= '0;
      op <= 3'd0;
      mask <= '0;
      res_q <= '0;
      tmr <= '0;
    end else begin
      snp_valid <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid && req_ready) begin
          req_ready <= 1'b0;
          op <= req_op;
          snp_op <= req_op;
          snp_addr <= req_addr;
          rsp_result <= 2'd0;
          if (!legal) begin
            err_bad_op <= 1'b1;
            rsp_valid <= 1'b1;
            state <= RESP;
          end else if (req_op == OP_WRITE) begin
            tmr <= CW'(MEM_LATENCY - 1);
            state <= MEM;
          end else begin
            snp_valid <= 1'b1;
            state <= BCAST;
          end
        end
        BCAST: begin
          mask <= '0;
          tmr <= '0;
          state <= COLLECT;
        end
        COLLECT: begin
          for (int i = 0; i < N_SNOOPERS; i++)
            if (snp_rsp_valid[i] && !mask[i]) res_q[2*i+:2] <= snp_rsp[2*i+:2];
          mask <= cap_mask;
          tmr <= tmr + CW'(1);
          if (all_cap || tmr_end) begin
            rsp_result <= comb_res;
            if (!all_cap) err_timeout <= 1'b1;
            if (hitm_multi) err_multi_hitm <= 1'b1;
            if (op == OP_INV) begin
              rsp_valid <= 1'b1;
              state <= RESP;
            end else if (hitm_any) begin
              tmr <= '0;
              state <= FLUSH;
            end else begin
              tmr <= CW'(MEM_LATENCY - 1);
              state <= MEM;
            end
          end
        end
        FLUSH: begin
          tmr <= tmr + CW'(1);
          if (wb_valid || tmr_end) begin
            if (!wb_valid) err_timeout <= 1'b1;
            tmr <= CW'(MEM_LATENCY - 1);
            state <= MEM;
          end
        end
        MEM: begin
          tmr <= tmr - CW'(1);
          if (tmr == '0) begin
            rsp_valid <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          op_count <= op_count + CNT_BITS'(op_count != '1);
          hitm_count <= hitm_count + CNT_BITS'(rsp_result == 2'd2 && hitm_count != '1);
          req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
